// File: rtl/speed_controller.sv
// Tick-rate controller: 4-level period divider with run/pause and boundary-aligned speed changes.
// Optional tick_count output enabled by defining SPEED_CTRL_TICK_COUNT_EN.
module speed_controller #(
  parameter int CNT_W      = 23,
  parameter int BASE_COUNT = 3000000
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       faster,
  input  logic       slower,
  input  logic       pause,
  output logic       tick,
  output logic [1:0] level,
  output logic       pending,
  output logic       paused
`ifdef SPEED_CTRL_TICK_COUNT_EN
  ,
  output logic [15:0] tick_count
`endif
);

  typedef enum logic {RUN, PAUSED} state_t;

  localparam logic [CNT_W-1:0] BASE = CNT_W'(BASE_COUNT);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [CNT_W-1:0] period;
  logic [1:0]       level_nxt;
  logic [1:0]       req_level, req_nxt;
  logic             tick_nxt;
  logic             wrap;

  // Period follows the active level only, so a pending request never bends the current interval.
  assign period  = BASE >> level;
  assign wrap    = (count == period - CNT_W'(1));
  assign pending = (req_level != level);
  assign paused  = (state == PAUSED);

  always_comb begin
    req_nxt = req_level;
    if (faster && !slower && req_level != 2'd3)
      req_nxt = req_level + 2'd1;
    else if (slower && !faster && req_level != 2'd0)
      req_nxt = req_level - 2'd1;
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    state_nxt = state;
    count_nxt = count;
    level_nxt = level;
    tick_nxt  = 1'b0;
    case (state)
      RUN: begin
        // A wrap landing on the pause edge still completes before the pause takes hold.
        if (wrap) begin
          count_nxt = '0;
          tick_nxt  = 1'b1;
          level_nxt = req_level;
        end else begin
          count_nxt = count + CNT_W'(1);
        end
        if (pause) state_nxt = PAUSED;
      end
      PAUSED: begin
        level_nxt = req_level;
        if (req_level != level) count_nxt = '0;
        if (pause) state_nxt = RUN;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= RUN;
      count     <= '0;
      level     <= 2'd0;
      req_level <= 2'd0;
      tick      <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      level     <= level_nxt;
      req_level <= req_nxt;
      tick      <= tick_nxt;
    end
  end

`ifdef SPEED_CTRL_TICK_COUNT_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      tick_count <= 16'd0;
    else if (tick)
      tick_count <= tick_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_speed_controller.sv
// Self-checking bench for speed_controller: vector table for level/pending/paused,
// plus a queue of expected tick cycles checked as ticks appear.
module tb_speed_controller;

  localparam int CNT_W      = 8;
  localparam int BASE_COUNT = 16;

  logic       clk    = 1'b0;
  logic       nrst   = 1'b1;
  logic       faster = 1'b0;
  logic       slower = 1'b0;
  logic       pause  = 1'b0;
  logic       tick;
  logic [1:0] level;
  logic       pending;
  logic       paused;
`ifdef SPEED_CTRL_TICK_COUNT_EN
  logic [15:0] tick_count;
`endif

  speed_controller #(
    .CNT_W      (CNT_W),
    .BASE_COUNT (BASE_COUNT)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .faster     (faster),
    .slower     (slower),
    .pause      (pause),
    .tick       (tick),
    .level      (level),
    .pending    (pending),
    .paused     (paused)
`ifdef SPEED_CTRL_TICK_COUNT_EN
    ,
    .tick_count (tick_count)
`endif
  );

  always #5 clk = ~clk;

  // cyc counts rising edges since reset release; entries drive inputs during cycle cyc
  // (sampled at edge cyc+1) and check outputs as seen after edge cyc.
  typedef struct {
    int         cyc;
    bit         rst;
    bit         f, s, p;
    int         tick_at;
    bit         chk;
    logic [1:0] level;
    logic       pending;
    logic       paused;
  } vec_t;

  vec_t vecs[$];
  int   exp_ticks[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   ticks_done = 0;
  int   last_tick = -1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t blank(input int c);
    vec_t e;
    e = '{default: 0};
    e.cyc = c;
    return e;
  endfunction

  function automatic void add_rst();
    vec_t e = blank(0);
    e.rst = 1'b1;
    vecs.push_back(e);
  endfunction

  function automatic void add_in(input int c, input bit f, input bit s, input bit p);
    vec_t e = blank(c);
    e.f = f; e.s = s; e.p = p;
    vecs.push_back(e);
  endfunction

  function automatic void add_tick(input int at);
    vec_t e = blank(0);
    e.tick_at = at;
    vecs.push_back(e);
  endfunction

  function automatic void add_chk(input int c, input logic [1:0] lv, input logic pd, input logic ps);
    vec_t e = blank(c);
    e.chk = 1'b1; e.level = lv; e.pending = pd; e.paused = ps;
    vecs.push_back(e);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    faster = 1'b0; slower = 1'b0; pause = 1'b0;
    cyc++;
    @(negedge clk);
    if (tick === 1'b1) begin
      if (exp_ticks.size() == 0) check("unexpected_tick", cyc, -1);
      else begin
        check("tick_cycle", cyc, exp_ticks.pop_front());
        ticks_done++;
        last_tick = cyc;
      end
    end else if (exp_ticks.size() > 0 && exp_ticks[0] <= cyc) begin
      check("missed_tick", -1, exp_ticks.pop_front());
    end
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    faster = 1'b0; slower = 1'b0; pause = 1'b0;
    #1;
    check("rst_tick",    int'(tick),    0);
    check("rst_level",   int'(level),   0);
    check("rst_pending", int'(pending), 0);
    check("rst_paused",  int'(paused),  0);
`ifdef SPEED_CTRL_TICK_COUNT_EN
    check("rst_tick_count", int'(tick_count), 0);
`endif
    while (exp_ticks.size() > 0) check("missed_tick", -1, exp_ticks.pop_front());
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    cyc = 0;
    ticks_done = 0;
    last_tick = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Free run at level 0; simultaneous pair and slower at level 0 change nothing.
    add_rst();
    add_tick(16); add_tick(32); add_tick(48);
    add_chk(0, 2'd0, 1'b0, 1'b0);
    add_in(20, 1, 1, 0);
    add_chk(21, 2'd0, 1'b0, 1'b0);
    add_in(25, 0, 1, 0);
    add_chk(26, 2'd0, 1'b0, 1'b0);
    add_chk(32, 2'd0, 1'b0, 1'b0);
    add_chk(50, 2'd0, 1'b0, 1'b0);

    // Single faster request applied at the first boundary.
    add_rst();
    add_tick(16); add_tick(24); add_tick(32);
    add_chk(5, 2'd0, 1'b0, 1'b0);
    add_in(5, 1, 0, 0);
    add_chk(6, 2'd0, 1'b1, 1'b0);
    add_chk(15, 2'd0, 1'b1, 1'b0);
    add_chk(16, 2'd1, 1'b0, 1'b0);
    add_chk(34, 2'd1, 1'b0, 1'b0);

    // Saturation at 3, then a simultaneous pair leaves it at 3.
    add_rst();
    for (int t = 16; t <= 30; t += 2) add_tick(t);
    for (int c = 1; c <= 5; c++) add_in(c, 1, 0, 0);
    add_in(6, 1, 1, 0);
    add_chk(7, 2'd0, 1'b1, 1'b0);
    add_chk(16, 2'd3, 1'b0, 1'b0);
    add_chk(31, 2'd3, 1'b0, 1'b0);

    // Pause mid-period, hold count, resume.
    add_rst();
    add_tick(36); add_tick(52);
    add_chk(9, 2'd0, 1'b0, 1'b0);
    add_in(9, 0, 0, 1);
    add_chk(10, 2'd0, 1'b0, 1'b1);
    add_chk(29, 2'd0, 1'b0, 1'b1);
    add_in(29, 0, 0, 1);
    add_chk(30, 2'd0, 1'b0, 1'b0);
    add_chk(53, 2'd0, 1'b0, 1'b0);

    // Pause landing on the wrap edge: tick and level update still happen.
    add_rst();
    add_tick(16); add_tick(29); add_tick(37);
    add_in(10, 1, 0, 0);
    add_in(15, 0, 0, 1);
    add_chk(16, 2'd1, 1'b0, 1'b1);
    add_in(20, 0, 0, 1);
    add_chk(21, 2'd1, 1'b0, 1'b0);
    add_chk(38, 2'd1, 1'b0, 1'b0);

    // Level change while paused clears the count.
    add_rst();
    add_tick(16); add_tick(20); add_tick(24); add_tick(41); add_tick(49);
    add_in(1, 1, 0, 0);
    add_in(2, 1, 0, 0);
    add_chk(15, 2'd0, 1'b1, 1'b0);
    add_chk(16, 2'd2, 1'b0, 1'b0);
    add_in(25, 0, 0, 1);
    add_chk(26, 2'd2, 1'b0, 1'b1);
    add_in(28, 0, 1, 0);
    add_chk(29, 2'd2, 1'b1, 1'b1);
    add_chk(30, 2'd1, 1'b0, 1'b1);
    add_in(32, 0, 0, 1);
    add_chk(33, 2'd1, 1'b0, 1'b0);
    add_chk(50, 2'd1, 1'b0, 1'b0);

    // Asynchronous reset at count 12 aborts the period and the pending request.
    add_rst();
    add_in(3, 1, 0, 0);
    add_chk(12, 2'd0, 1'b1, 1'b0);
    add_rst();
    add_chk(0, 2'd0, 1'b0, 1'b0);
    add_tick(16); add_tick(32);
    add_chk(33, 2'd0, 1'b0, 1'b0);

    #2;
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t e;
      e = vecs[i];
      if (e.rst) do_reset();
      while (cyc < e.cyc) step();
      if (e.chk) begin
        check("level",   int'(level),   int'(e.level));
        check("pending", int'(pending), int'(e.pending));
        check("paused",  int'(paused),  int'(e.paused));
`ifdef SPEED_CTRL_TICK_COUNT_EN
        check("tick_count", int'(tick_count), ticks_done - ((last_tick == cyc) ? 1 : 0));
`endif
      end
      if (e.tick_at > 0) exp_ticks.push_back(e.tick_at);
      if (e.f) faster = 1'b1;
      if (e.s) slower = 1'b1;
      if (e.p) pause  = 1'b1;
    end
    while (exp_ticks.size() > 0) check("missed_tick", -1, exp_ticks.pop_front());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
